// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_pkg
// Brief  : Shared types and default widths for the main-memory arbiter.
// Rev    : 1.0
// ============================================================================
package mem_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_LINE_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module : mem_arb_pick
// Brief  : Grant selection; dcache first unless its streak limit is reached.
// Rev    : 1.0
// ============================================================================
module mem_arb_pick
  import mem_pkg::*;
#(
  parameter int MAX_DC_RUN = 4,
  parameter int RUN_W      = $clog2(MAX_DC_RUN + 1)
) (
  input  logic             ic_req,
  input  logic             dc_req,
  input  logic [RUN_W-1:0] dc_run,
  output owner_t           owner
);

  localparam logic [RUN_W-1:0] c_RUN_MAX = RUN_W'(MAX_DC_RUN);

  logic w_icTurn;

  // A waiting fetch preempts the dcache once the streak is exhausted
  assign w_icTurn = ic_req && (dc_run == c_RUN_MAX);

  always_comb begin
    owner = OWN_IC;
    if (dc_req && !w_icTurn) begin
      owner = OWN_DC;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_arbiter
// Brief  : Shares one memory port between icache and dcache miss traffic.
// Rev    : 1.0
// ============================================================================
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int LINE_W     = MEM_LINE_W,
  parameter int MAX_DC_RUN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_done,
  output logic [LINE_W-1:0] ic_rdata,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic              dc_done,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_rdata
);

  localparam int              RUN_W     = $clog2(MAX_DC_RUN + 1);
  localparam logic [RUN_W-1:0] c_RUN_MAX = RUN_W'(MAX_DC_RUN);

  state_t           r_state;
  state_t           w_stateNext;
  owner_t           r_owner;
  owner_t           w_pick;
  logic [RUN_W-1:0] r_dcRun;
  logic             w_grant;
  logic             w_ack;

  mem_arb_pick #(
    .MAX_DC_RUN (MAX_DC_RUN),
    .RUN_W      (RUN_W)
  ) u_pick (
    .ic_req (ic_req),
    .dc_req (dc_req),
    .dc_run (r_dcRun),
    .owner  (w_pick)
  );

  always_comb begin
    w_stateNext = r_state;
    w_grant     = 1'b0;
    w_ack       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ic_req || dc_req) begin
          w_stateNext = ST_BUSY;
          w_grant     = 1'b1;
        end
      end
      ST_BUSY: begin
        if (mem_ack) begin
          w_stateNext = ST_RESP;
          w_ack       = 1'b1;
        end
      end
      ST_RESP: begin
        w_stateNext = ST_IDLE;
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_owner   <= OWN_IC;
      r_dcRun   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ic_done   <= 1'b0;
      dc_done   <= 1'b0;
      ic_rdata  <= '0;
      dc_rdata  <= '0;
    end else begin
      r_state <= w_stateNext;
      ic_done <= 1'b0;
      dc_done <= 1'b0;

      // Transaction fields are frozen here; later req/addr changes are ignored
      if (w_grant) begin
        r_owner <= w_pick;
        mem_req <= 1'b1;
        if (w_pick == OWN_DC) begin
          mem_we    <= dc_we;
          mem_addr  <= dc_addr;
          mem_wdata <= dc_wdata;
          if (!ic_req) begin
            r_dcRun <= '0;
          end else if (r_dcRun != c_RUN_MAX) begin
            r_dcRun <= r_dcRun + RUN_W'(1);
          end
        end else begin
          mem_we    <= 1'b0;
          mem_addr  <= ic_addr;
          mem_wdata <= '0;
          r_dcRun   <= '0;
        end
      end

      if (w_ack) begin
        mem_req <= 1'b0;
        if (r_owner == OWN_IC) begin
          ic_done  <= 1'b1;
          ic_rdata <= mem_rdata;
        end else begin
          dc_done <= 1'b1;
          if (!mem_we) begin
            dc_rdata <= mem_rdata;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_arbiter
// Brief  : Directed self-checking bench for mem_arbiter.
// Rev    : 1.0
// ============================================================================
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          ic_req;
  logic [AW-1:0] ic_addr;
  logic          ic_done;
  logic [LW-1:0] ic_rdata;
  logic          dc_req;
  logic          dc_we;
  logic [AW-1:0] dc_addr;
  logic [LW-1:0] dc_wdata;
  logic          dc_done;
  logic [LW-1:0] dc_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic          mem_ack;
  logic [LW-1:0] mem_rdata;

  int ntests = 0;
  int nfail  = 0;

  localparam logic [LW-1:0] L1   = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [LW-1:0] L2   = 128'hFEDC_BA98_7654_3210_8899_AABB_CCDD_EEFF;
  localparam logic [LW-1:0] L3   = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [LW-1:0] A5   = {16{8'hA5}};
  localparam logic [LW-1:0] JUNK = {LW{1'b1}};

  mem_arbiter #(
    .ADDR_W     (AW),
    .LINE_W     (LW),
    .MAX_DC_RUN (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ic_req    (ic_req),
    .ic_addr   (ic_addr),
    .ic_done   (ic_done),
    .ic_rdata  (ic_rdata),
    .dc_req    (dc_req),
    .dc_we     (dc_we),
    .dc_addr   (dc_addr),
    .dc_wdata  (dc_wdata),
    .dc_done   (dc_done),
    .dc_rdata  (dc_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    ic_req    = 1'b0;
    ic_addr   = '0;
    dc_req    = 1'b0;
    dc_we     = 1'b0;
    dc_addr   = '0;
    dc_wdata  = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    idleInputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    ntests++; if (mem_req !== 1'b0) begin nfail++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
    ntests++; if (mem_we !== 1'b0) begin nfail++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    ntests++; if (mem_addr !== '0) begin nfail++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    ntests++; if (mem_wdata !== '0) begin nfail++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
    ntests++; if ({ic_done, dc_done} !== 2'b00) begin nfail++; $display("FAIL rst_done: got %b want 00", {ic_done, dc_done}); end
    ntests++; if (ic_rdata !== '0) begin nfail++; $display("FAIL rst_ic_rdata: got %h want 0", ic_rdata); end
    ntests++; if (dc_rdata !== '0) begin nfail++; $display("FAIL rst_dc_rdata: got %h want 0", dc_rdata); end
    // Stray ack with nobody requesting
    mem_ack   = 1'b1;
    mem_rdata = JUNK;
    tick();
    tick();
    ntests++; if ({mem_req, ic_done, dc_done} !== 3'b000) begin nfail++; $display("FAIL idle_ack_ignored: got %b want 000", {mem_req, ic_done, dc_done}); end
    ntests++; if ({ic_rdata, dc_rdata} !== '0) begin nfail++; $display("FAIL idle_ack_rdata: got %h want 0", {ic_rdata, dc_rdata}); end
    mem_ack = 1'b0;
  endtask

  task automatic test_ic_read();
    doReset();
    ic_req  = 1'b1;
    ic_addr = 32'h0000_1000;
    tick();
    ntests++; if (mem_req !== 1'b1) begin nfail++; $display("FAIL ic_mem_req: got %b want 1", mem_req); end
    ntests++; if (mem_addr !== 32'h0000_1000) begin nfail++; $display("FAIL ic_mem_addr: got %h want 00001000", mem_addr); end
    ntests++; if (mem_we !== 1'b0) begin nfail++; $display("FAIL ic_mem_we: got %b want 0", mem_we); end
    repeat (3) begin
      tick();
      ntests++; if ({mem_req, ic_done} !== 2'b10) begin nfail++; $display("FAIL ic_wait: got req/done %b want 10", {mem_req, ic_done}); end
    end
    mem_ack   = 1'b1;
    mem_rdata = L1;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = JUNK;
    ntests++; if ({mem_req, ic_done, dc_done} !== 3'b010) begin nfail++; $display("FAIL ic_done_pulse: got req/ic/dc %b want 010", {mem_req, ic_done, dc_done}); end
    ntests++; if (ic_rdata !== L1) begin nfail++; $display("FAIL ic_rdata: got %h want %h", ic_rdata, L1); end
    ic_req = 1'b0;
    tick();
    ntests++; if (ic_done !== 1'b0) begin nfail++; $display("FAIL ic_done_width: got %b want 0", ic_done); end
    ntests++; if (ic_rdata !== L1) begin nfail++; $display("FAIL ic_rdata_hold: got %h want %h", ic_rdata, L1); end
  endtask

  task automatic test_dc_write();
    doReset();
    dc_req  = 1'b1;
    dc_we   = 1'b0;
    dc_addr = 32'h0000_2000;
    tick();
    mem_ack   = 1'b1;
    mem_rdata = L2;
    tick();
    mem_ack = 1'b0;
    ntests++; if ({dc_done, dc_rdata} !== {1'b1, L2}) begin nfail++; $display("FAIL dc_fill: got done %b data %h want 1 %h", dc_done, dc_rdata, L2); end
    dc_req = 1'b0;
    tick();
    dc_req   = 1'b1;
    dc_we    = 1'b1;
    dc_addr  = 32'h0000_2040;
    dc_wdata = A5;
    tick();
    ntests++; if ({mem_req, mem_we} !== 2'b11) begin nfail++; $display("FAIL dc_wr_req_we: got %b want 11", {mem_req, mem_we}); end
    ntests++; if (mem_addr !== 32'h0000_2040) begin nfail++; $display("FAIL dc_wr_addr: got %h want 00002040", mem_addr); end
    ntests++; if (mem_wdata !== A5) begin nfail++; $display("FAIL dc_wr_wdata: got %h want %h", mem_wdata, A5); end
    tick();
    mem_ack   = 1'b1;
    mem_rdata = JUNK;
    tick();
    mem_ack = 1'b0;
    ntests++; if ({dc_done, ic_done} !== 2'b10) begin nfail++; $display("FAIL dc_wr_done: got dc/ic %b want 10", {dc_done, ic_done}); end
    ntests++; if (dc_rdata !== L2) begin nfail++; $display("FAIL dc_wr_rdata_kept: got %h want %h", dc_rdata, L2); end
    dc_req = 1'b0;
    tick();
    ntests++; if (dc_done !== 1'b0) begin nfail++; $display("FAIL dc_wr_done_width: got %b want 0", dc_done); end
  endtask

  task automatic test_arbitration();
    doReset();
    ic_req  = 1'b1;
    ic_addr = 32'h0000_0100;
    dc_req  = 1'b1;
    dc_we   = 1'b0;
    dc_addr = 32'h0000_0200;
    for (int g = 0; g < 10; g++) begin
      int w;
      logic expIc;
      w = 0;
      while (!mem_req && w < 6) begin
        tick();
        w++;
      end
      expIc = (g % 5) == 4;
      ntests++;
      if (!mem_req) begin
        nfail++; $display("FAIL arb_grant%0d: no mem_req within 6 cycles", g);
        break;
      end
      if (mem_addr !== (expIc ? 32'h0000_0100 : 32'h0000_0200)) begin
        nfail++; $display("FAIL arb_grant%0d: got addr %h want %s", g, mem_addr, expIc ? "IC 00000100" : "DC 00000200");
      end
      mem_ack   = 1'b1;
      mem_rdata = L3;
      tick();
      mem_ack = 1'b0;
      ntests++; if ({ic_done, dc_done} !== {expIc, ~expIc}) begin nfail++; $display("FAIL arb_done%0d: got ic/dc %b want %b", g, {ic_done, dc_done}, {expIc, ~expIc}); end
      tick();
    end
    idleInputs();
    tick();
  endtask

  task automatic test_drop_req();
    doReset();
    ic_req  = 1'b1;
    ic_addr = 32'h0000_3000;
    tick();
    ic_req  = 1'b0;
    ic_addr = 32'hFFFF_FFC0;
    repeat (3) begin
      tick();
      ntests++; if ({mem_req, mem_addr} !== {1'b1, 32'h0000_3000}) begin nfail++; $display("FAIL drop_hold: got req %b addr %h want 1 00003000", mem_req, mem_addr); end
    end
    mem_ack   = 1'b1;
    mem_rdata = L3;
    tick();
    mem_ack = 1'b0;
    ntests++; if ({ic_done, ic_rdata} !== {1'b1, L3}) begin nfail++; $display("FAIL drop_done: got done %b data %h want 1 %h", ic_done, ic_rdata, L3); end
    repeat (3) begin
      tick();
      ntests++; if ({mem_req, ic_done} !== 2'b00) begin nfail++; $display("FAIL drop_after: got req/done %b want 00", {mem_req, ic_done}); end
    end
  endtask

  task automatic test_reset_mid();
    doReset();
    dc_req  = 1'b1;
    dc_we   = 1'b0;
    dc_addr = 32'h0000_4000;
    tick();
    tick();
    ntests++; if (mem_req !== 1'b1) begin nfail++; $display("FAIL rstmid_busy: got req %b want 1", mem_req); end
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    dc_req = 1'b0;
    ntests++; if ({mem_req, dc_done} !== 2'b00) begin nfail++; $display("FAIL rstmid_abort: got req/done %b want 00", {mem_req, dc_done}); end
    mem_ack   = 1'b1;
    mem_rdata = L1;
    tick();
    mem_ack = 1'b0;
    ntests++; if ({mem_req, dc_done, ic_done} !== 3'b000) begin nfail++; $display("FAIL rstmid_late_ack: got req/dc/ic %b want 000", {mem_req, dc_done, ic_done}); end
    tick();
    ntests++; if ({dc_done, dc_rdata} !== {1'b0, {LW{1'b0}}}) begin nfail++; $display("FAIL rstmid_rdata: got done %b data %h want 0 0", dc_done, dc_rdata); end
  endtask

  task automatic test_same_cycle_ack();
    doReset();
    dc_req  = 1'b1;
    dc_we   = 1'b0;
    dc_addr = 32'h0000_5000;
    ic_req  = 1'b1;
    ic_addr = 32'h0000_6000;
    tick();
    ntests++; if ({mem_req, mem_addr} !== {1'b1, 32'h0000_5000}) begin nfail++; $display("FAIL sca_grant_dc: got req %b addr %h want 1 00005000", mem_req, mem_addr); end
    mem_ack   = 1'b1;
    mem_rdata = L2;
    tick();
    mem_ack = 1'b0;
    ntests++; if ({dc_done, dc_rdata} !== {1'b1, L2}) begin nfail++; $display("FAIL sca_done: got done %b data %h want 1 %h", dc_done, dc_rdata, L2); end
    dc_req = 1'b0;
    tick();
    ntests++; if ({mem_req, dc_done} !== 2'b00) begin nfail++; $display("FAIL sca_idle: got req/done %b want 00", {mem_req, dc_done}); end
    tick();
    ntests++; if ({mem_req, mem_addr} !== {1'b1, 32'h0000_6000}) begin nfail++; $display("FAIL sca_next_ic: got req %b addr %h want 1 00006000", mem_req, mem_addr); end
    mem_ack   = 1'b1;
    mem_rdata = L1;
    tick();
    mem_ack = 1'b0;
    ntests++; if ({ic_done, ic_rdata} !== {1'b1, L1}) begin nfail++; $display("FAIL sca_ic_done: got done %b data %h want 1 %h", ic_done, ic_rdata, L1); end
    idleInputs();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idleInputs();
    test_reset();
    test_ic_read();
    test_dc_write();
    test_arbitration();
    test_drop_req();
    test_reset_mid();
    test_same_cycle_ack();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
`default_nettype wire
